// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces 4 buttons and 4 switches,
// producing press/release/long-press pulses and a switch-change pulse.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [3:0] sw_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_long,
  output logic [3:0] sw_level,
  output logic       sw_changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  logic [7:0] raw, meta, s, level, flip;
  logic [CW-1:0] cnt [8];
  logic [HW-1:0] hold [4];
  assign raw = {sw_raw, btn_raw};
  assign btn_level = level[3:0];
  assign sw_level = level[7:4];
  always_ff @(posedge sclk or posedge reset)
    if (reset) begin
      meta <= '0;
      s <= '0;
    end else begin
      meta <= raw;
      s <= meta;
    end
  // flip marks the edge on which a channel's debounced level takes the sync value
  always_comb begin
    flip = '0;
    for (int i = 0; i < 8; i++)
      flip[i] = (s[i] != level[i]) && (cnt[i] == CNT_LAST);
  end
  always_ff @(posedge sclk or posedge reset)
    if (reset) begin
      level <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      level <= level ^ flip;
      for (int i = 0; i < 8; i++)
        cnt[i] <= (s[i] == level[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
  always_ff @(posedge sclk or posedge reset)
    if (reset) begin
      btn_press <= '0;
      btn_release <= '0;
      btn_long <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      btn_press <= flip[3:0] & s[3:0];
      btn_release <= flip[3:0] & ~s[3:0];
      sw_changed <= |flip[7:4];
      for (int i = 0; i < 4; i++) begin
        btn_long[i] <= level[i] && hold[i] == HOLD_LAST;
        hold[i] <= !level[i] ? '0 : (hold[i] == HOLD_MAX ? hold[i] : hold[i] + 1'b1);
      end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; expected pulse events are queued with
// their due cycle when stimulus is driven and matched as the DUT emits pulses.
module tb_input_conditioner;
  localparam int D = 4;
  localparam int L = 20;
  logic sclk, reset;
  logic [3:0] btn_raw, sw_raw, btn_level, btn_press, btn_release, btn_long, sw_level;
  logic sw_changed;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct { int cyc; logic [12:0] v; } ev_t;
  ev_t exp_q[$];

  input_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .sclk(sclk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .sw_level(sw_level), .sw_changed(sw_changed)
  );

  initial sclk = 0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [12:0] pr(input int i); return 13'(1) << i; endfunction
  function automatic logic [12:0] rl(input int i); return 13'(1) << (4 + i); endfunction
  function automatic logic [12:0] lg(input int i); return 13'(1) << (8 + i); endfunction
  localparam logic [12:0] SWC = 13'h1000;

  task automatic push(input int c, input logic [12:0] v);
    ev_t e;
    e.cyc = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  always @(negedge sclk) begin
    logic [12:0] obs;
    ev_t e;
    obs = {sw_changed, btn_long, btn_release, btn_press};
    if (obs != 0) begin
      if (exp_q.size() == 0) chk("spurious", 32'(obs), 0);
      else begin
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_value", 32'(obs), 32'(e.v));
      end
    end
  end

  initial begin
    int n;
    reset = 1;
    btn_raw = 0;
    sw_raw = 0;
    #3;
    chk("rst_btn_level", 32'(btn_level), 0);
    chk("rst_btn_press", 32'(btn_press), 0);
    chk("rst_btn_release", 32'(btn_release), 0);
    chk("rst_btn_long", 32'(btn_long), 0);
    chk("rst_sw_level", 32'(sw_level), 0);
    chk("rst_sw_changed", 32'(sw_changed), 0);
    repeat (3) @(negedge sclk);
    reset = 0;
    wait_to(cyc + 3);

    // clean press, released before the long-press threshold
    n = cyc;
    btn_raw[0] = 1;
    push(n + 6, pr(0));
    wait_to(n + 5);
    chk("clean_level_before", 32'(btn_level[0]), 0);
    wait_to(n + 6);
    chk("clean_level_after", 32'(btn_level[0]), 1);
    wait_to(n + 10);
    btn_raw[0] = 0;
    push(n + 16, rl(0));
    wait_to(n + 40);
    chk("clean_level_released", 32'(btn_level[0]), 0);

    // bounce shorter than the debounce window never propagates
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      btn_raw[1] = ~k[0];
      wait_to(n + 2 * (k + 1));
    end
    btn_raw[1] = 1;
    chk("bounce_level_during", 32'(btn_level[1]), 0);
    push(n + 14, pr(1));
    wait_to(n + 14);
    chk("bounce_level_after", 32'(btn_level[1]), 1);
    wait_to(n + 20);
    btn_raw[1] = 0;
    push(n + 26, rl(1));
    wait_to(n + 40);

    // long press, then a short press without long pulse
    n = cyc;
    btn_raw[2] = 1;
    push(n + 6, pr(2));
    push(n + 26, lg(2));
    wait_to(n + 40);
    btn_raw[2] = 0;
    push(n + 46, rl(2));
    wait_to(n + 60);
    n = cyc;
    btn_raw[2] = 1;
    push(n + 6, pr(2));
    wait_to(n + 10);
    btn_raw[2] = 0;
    push(n + 16, rl(2));
    wait_to(n + 50);

    // multi-bit switch change yields one pulse
    n = cyc;
    sw_raw = 4'b1010;
    push(n + 6, SWC);
    wait_to(n + 5);
    chk("sw_level_before", 32'(sw_level), 0);
    wait_to(n + 6);
    chk("sw_level_after", 32'(sw_level), 32'b1010);
    wait_to(n + 15);
    sw_raw = 4'b0000;
    push(n + 21, SWC);
    wait_to(n + 30);
    chk("sw_level_back", 32'(sw_level), 0);

    // independent channels changing together
    n = cyc;
    btn_raw[0] = 1;
    sw_raw[0] = 1;
    push(n + 6, pr(0) | SWC);
    wait_to(n + 8);
    btn_raw[0] = 0;
    sw_raw[0] = 0;
    push(n + 14, rl(0) | SWC);
    wait_to(n + 30);

    // reset mid-press: no release or long for the interrupted press
    n = cyc;
    btn_raw[3] = 1;
    push(n + 6, pr(3));
    wait_to(n + 10);
    chk("midpress_level", 32'(btn_level[3]), 1);
    reset = 1;
    #1;
    chk("midreset_btn_level", 32'(btn_level), 0);
    chk("midreset_outputs", 32'({sw_changed, btn_long, btn_release, btn_press}), 0);
    wait_to(n + 13);
    reset = 0;
    n = cyc;
    push(n + 6, pr(3));
    wait_to(n + 10);
    btn_raw[3] = 0;
    push(n + 16, rl(3));
    wait_to(n + 40);
    chk("final_btn_level", 32'(btn_level), 0);
    chk("pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive mismatch cycles (10 ms at 100 MHz) before a debounced level changes; legal range >= 2.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 50000000, meaning stable-pressed cycles (0.5 s) before a long-press pulse; legal range > DEBOUNCE_CYCLES.
REQ-003 SHALL have port sclk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port btn_raw, input, 4, unsynchronized push-button pins.
REQ-006 SHALL have port sw_raw, input, 4, unsynchronized slide-switch pins.
REQ-007 SHALL have port btn_level, output, 4, debounced button levels.
REQ-008 SHALL have port btn_press, output, 4, one-cycle pulse per button on each debounced 0->1 transition.
REQ-009 SHALL have port btn_release, output, 4, one-cycle pulse per button on each debounced 1->0 transition.
REQ-010 SHALL have port btn_long, output, 4, one-cycle pulse per button when a press is held LONG_PRESS_CYCLES.
REQ-011 SHALL have port sw_level, output, 4, debounced switch value.
REQ-012 SHALL have port sw_changed, output, 1, one-cycle pulse when any bit of sw_level changes.

Function
REQ-013 SHALL pass each of the 8 raw inputs through a 2-flop synchronizer; second-flop output is the channel's sync value s.
REQ-014 SHALL keep one debounce counter per channel, width ceil(log2(DEBOUNCE_CYCLES)), cleared on any edge where s equals the channel's debounced level.
REQ-015 SHALL increment the counter on each edge where s differs from the debounced level; on the edge where the counter equals DEBOUNCE_CYCLES-1 and s still differs, the level SHALL take s and the counter SHALL clear.
REQ-016 SHALL produce a debounced change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling a new raw value that is then held steady.
REQ-017 SHALL restart the count from 0 whenever s returns to the debounced level before the threshold (bounce shorter than DEBOUNCE_CYCLES never propagates).
REQ-018 SHALL register btn_press[i] / btn_release[i] high on the same edge btn_level[i] rises / falls, low on the next edge; press and release of one button are never high together.
REQ-019 SHALL keep one hold counter per button, width ceil(log2(LONG_PRESS_CYCLES+1)), cleared while btn_level[i]=0, incrementing while btn_level[i]=1, saturating at LONG_PRESS_CYCLES.
REQ-020 SHALL pulse btn_long[i] for one cycle on the edge the hold counter first reaches LONG_PRESS_CYCLES; at most one btn_long pulse per press; none if released earlier.
REQ-021 SHALL pulse sw_changed for one cycle on the edge any sw_level bit changes; simultaneous multi-bit changes yield one pulse.
REQ-022 SHALL process all channels independently; simultaneous events on different channels each produce their own pulses in the same cycle.

Reset
REQ-023 SHALL, while reset=1, asynchronously clear synchronizer flops, all counters and every output (btn_level, btn_press, btn_release, btn_long, sw_level, sw_changed all 0).
REQ-024 SHALL treat inputs high at reset release as new transitions: btn_press / sw_changed fire after the REQ-016 latency.
REQ-025 SHALL, if reset asserts mid-press or mid-count, produce no btn_release or btn_long for that press.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-026 Clean press: btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 for one cycle 6 edges later.
REQ-027 Bounce: btn_raw[1] toggles 1,0,1,0 every 2 cycles then holds 1 -> single btn_press[1] 6 edges after final rise; no btn_release[1].
REQ-028 Long press: btn_raw[2] held 40 cycles then released -> btn_long[2] one pulse 20 edges after btn_press[2]; btn_release[2] 6 edges after release; held 10 cycles -> no btn_long.
REQ-029 Switches: sw_raw 0000->1010 in one cycle -> sw_level=1010 with one sw_changed pulse 6 edges later.
REQ-030 Reset mid-press: reset pulsed while btn_level[3]=1 and btn_raw[3] held -> outputs 0 immediately, no btn_release[3]; btn_press[3] 6 edges after reset release.
